// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore FSM, condition-gated enables and an NZCV flags register.
// Define BRANCH_LINK_EN to add the BLWB state for branch-with-link.
module multicycle_controller (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] op_i,
    input  logic [5:0] funct_i,
    input  logic [3:0] rd_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_control_o,
    output logic [1:0] imm_src_o,
    output logic [1:0] reg_src_o,
    output logic       link_sel_o
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StExecI,
        StAluWb,
        StBranch
`ifdef BRANCH_LINK_EN
        , StBlWb
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [1:0] alu_dec;
    logic       cond_ex;
    logic       ir_w, pc_w, reg_w, mem_w, branch_st, wb_st;
`ifdef BRANCH_LINK_EN
    logic       link;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFetch;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                unique case (op_i)
                    2'b00: state_d = funct_i[5] ? StExecI : StExecR;
                    2'b01: state_d = StMemAdr;
`ifdef BRANCH_LINK_EN
                    2'b10: state_d = funct_i[4] ? StBlWb : StBranch;
`else
                    2'b10: state_d = StBranch;
`endif
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = funct_i[0] ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = StFetch;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
`ifdef BRANCH_LINK_EN
            StBlWb:   state_d = StBranch;
`endif
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        unique case (funct_i[4:1])
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            default: alu_dec = 2'b00;
        endcase
    end

    // flags_q is {N, Z, C, V}
    always_comb begin
        unique case (cond_i)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = !flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = !flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = !flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = !flags_q[0];
            4'b1000: cond_ex = flags_q[1] && !flags_q[2];
            4'b1001: cond_ex = !flags_q[1] || flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // C and V only follow the ALU for arithmetic ops; logical ops keep them
    always_comb begin
        flags_d = flags_q;
        if ((state_q == StExecR || state_q == StExecI) && cond_ex && funct_i[0]) begin
            flags_d[3:2] = alu_flags_i[3:2];
            if (!alu_dec[1]) begin
                flags_d[1:0] = alu_flags_i[1:0];
            end
        end
    end

    always_comb begin
        ir_w          = 1'b0;
        pc_w          = 1'b0;
        reg_w         = 1'b0;
        mem_w         = 1'b0;
        branch_st     = 1'b0;
        wb_st         = 1'b0;
        adr_src_o     = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        result_src_o  = 2'b00;
        alu_control_o = 2'b00;
`ifdef BRANCH_LINK_EN
        link          = 1'b0;
`endif
        unique case (state_q)
            StFetch: begin
                ir_w         = 1'b1;
                pc_w         = 1'b1;
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
            end
            StDecode: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
            end
            StMemAdr: alu_src_b_o = 2'b01;
            StMemRd:  adr_src_o = 1'b1;
            StMemWr: begin
                adr_src_o = 1'b1;
                mem_w     = 1'b1;
            end
            StMemWb: begin
                result_src_o = 2'b01;
                reg_w        = 1'b1;
                wb_st        = 1'b1;
            end
            StExecR:  alu_control_o = alu_dec;
            StExecI: begin
                alu_src_b_o   = 2'b01;
                alu_control_o = alu_dec;
            end
            StAluWb: begin
                reg_w = 1'b1;
                wb_st = 1'b1;
            end
            StBranch: begin
                alu_src_b_o  = 2'b01;
                result_src_o = 2'b10;
                branch_st    = 1'b1;
            end
`ifdef BRANCH_LINK_EN
            StBlWb: begin
                link         = 1'b1;
                result_src_o = 2'b11;
                reg_w        = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Enables are also masked by rst_ni so they drop the instant reset asserts
    assign ir_write_o  = ir_w && rst_ni;
    assign reg_write_o = reg_w && cond_ex && rst_ni;
    assign mem_write_o = mem_w && cond_ex && rst_ni;
    assign pc_write_o  = rst_ni &&
                         (pc_w || (cond_ex && (branch_st || (wb_st && rd_i == 4'b1111))));
    assign imm_src_o   = op_i;
    assign reg_src_o   = {op_i == 2'b01, op_i == 2'b10};
`ifdef BRANCH_LINK_EN
    assign link_sel_o  = link && rst_ni;
`else
    assign link_sel_o  = 1'b0;
`endif

endmodule
